// File: rtl/gtxe2_chnl_rx_syncfsm_if.sv
// rtl/gtxe2_chnl_rx_syncfsm_if.sv - decoder flag bus and sync status for the RX sync FSM
interface gtxe2_chnl_rx_syncfsm_if #(
  parameter int lanes = 2
);
  logic             en;
  logic [lanes-1:0] chariscomma;
  logic [lanes-1:0] charisk;
  logic [lanes-1:0] disperr;
  logic [lanes-1:0] notintable;
  logic             sync_ok;
  logic             sync_lost;
  logic             rx_even;
  logic [3:0]       state;
  logic [15:0]      err_cnt;

  modport master (
    output en, chariscomma, charisk, disperr, notintable,
    input  sync_ok, sync_lost, rx_even, state, err_cnt
  );

  modport slave (
    input  en, chariscomma, charisk, disperr, notintable,
    output sync_ok, sync_lost, rx_even, state, err_cnt
  );
endinterface

// File: rtl/gtxe2_chnl_rx_syncfsm.sv
// rtl/gtxe2_chnl_rx_syncfsm.sv - comma-based character sync FSM; GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN enables err_cnt
module gtxe2_chnl_rx_syncfsm #(
  parameter int lanes        = 2,
  parameter int GOOD_CGS_MAX = 3
) (
  input logic                    clk,
  input logic                    rst,
  gtxe2_chnl_rx_syncfsm_if.slave bus
);
  localparam int GW = $clog2(GOOD_CGS_MAX + 1);

  typedef enum logic [3:0] {
    LOS = 4'd0, CD1 = 4'd1, AS1 = 4'd2, CD2 = 4'd3, AS2 = 4'd4,
    CD3 = 4'd5, SA1 = 4'd6, SA2 = 4'd7, SA3 = 4'd8, SA4 = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic            even_q, even_d;
  logic [GW-1:0]   good_q, good_d;
  logic            lost_q, lost_d;
  logic            comma, cg_bad, cg_data, realign;
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
  localparam int CW = $clog2(lanes + 1);
  logic [CW-1:0]   nbad;
`endif

  // Walk the word's characters in lane order; only the final state is registered.
  always_comb begin
    state_d = state_q;
    even_d  = even_q;
    good_d  = good_q;
    lost_d  = 1'b0;
    comma   = 1'b0;
    cg_bad  = 1'b0;
    cg_data = 1'b0;
    realign = 1'b0;
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
    nbad    = '0;
`endif
    if (bus.en) begin
      for (int i = 0; i < lanes; i++) begin
        comma   = bus.chariscomma[i];
        // A comma landing on an odd position (phase already even) is misaligned.
        cg_bad  = bus.notintable[i] | bus.disperr[i] | (comma & even_d);
        cg_data = ~bus.charisk[i] & ~bus.notintable[i] & ~bus.disperr[i];
        realign = 1'b0;
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
        if (state_d != LOS && cg_bad) nbad = nbad + 1'b1;
`endif
        case (state_d)
          LOS: if (comma) begin
            state_d = CD1;
            realign = 1'b1;
          end
          CD1: state_d = cg_data ? AS1 : LOS;
          CD2: state_d = cg_data ? AS2 : LOS;
          CD3: state_d = cg_data ? SA1 : LOS;
          AS1, AS2: begin
            if (cg_bad) begin
              state_d = LOS;
            end else if (comma) begin
              state_d = (state_d == AS1) ? CD2 : CD3;
              realign = 1'b1;
            end
          end
          SA1: if (cg_bad) begin
            state_d = SA2;
            good_d  = '0;
          end
          SA2, SA3, SA4: begin
            if (cg_bad) begin
              good_d = '0;
              if (state_d == SA4) begin
                state_d = LOS;
                lost_d  = 1'b1;
              end else begin
                state_d = state_t'(state_d + 4'd1);
              end
            end else if (good_d == GW'(GOOD_CGS_MAX - 1)) begin
              good_d  = '0;
              state_d = state_t'(state_d - 4'd1);
            end else begin
              good_d = good_d + 1'b1;
            end
          end
          default: state_d = LOS;
        endcase
        even_d = realign ? 1'b1 : ~even_d;
      end
    end
  end

  // State, phase, good-run counter and loss pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOS;
      even_q  <= 1'b0;
      good_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      even_q  <= even_d;
      good_q  <= good_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.sync_ok   = (state_q >= SA1);
  assign bus.sync_lost = lost_q;
  assign bus.rx_even   = even_q;
  assign bus.state     = state_q;

`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
  logic [15:0] err_q;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_q} + 17'(nbad);

  // Saturating bad-character counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (bus.en) begin
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_gtxe2_chnl_rx_syncfsm.sv
// tb/tb_gtxe2_chnl_rx_syncfsm.sv - directed and random checks of the RX sync FSM against a reference model
module tb_gtxe2_chnl_rx_syncfsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  gtxe2_chnl_rx_syncfsm_if #(.lanes(2)) bus ();

  gtxe2_chnl_rx_syncfsm #(.lanes(2), .GOOD_CGS_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: acquisition progress (commas accepted, waiting for data or comma)
  // and, once synced, a loss level 0..3 with a run of good characters.
  bit m_sync, m_wantdata, m_even, m_lost;
  int m_acq, m_level, m_good, m_err;

  task automatic model_reset();
    m_sync = 0; m_wantdata = 0; m_even = 0; m_lost = 0;
    m_acq = 0; m_level = 0; m_good = 0; m_err = 0;
  endtask

  task automatic model_char(input bit cm, input bit k, input bit de, input bit ni);
    bit bad, data, realign;
    bad = ni | de | (cm & m_even);
    data = !k && !ni && !de;
    realign = 0;
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
    if ((m_sync || m_acq != 0) && bad && m_err < 65535) m_err++;
`endif
    if (!m_sync) begin
      if (m_acq == 0) begin
        if (cm) begin m_acq = 1; m_wantdata = 1; realign = 1; end
      end else if (m_wantdata) begin
        if (!data) m_acq = 0;
        else if (m_acq == 3) begin m_sync = 1; m_level = 0; m_good = 0; end
        else m_wantdata = 0;
      end else begin
        if (bad) m_acq = 0;
        else if (cm) begin m_acq++; m_wantdata = 1; realign = 1; end
      end
    end else begin
      if (bad) begin
        m_good = 0;
        if (m_level == 3) begin m_sync = 0; m_acq = 0; m_lost = 1; end
        else m_level++;
      end else if (m_level > 0) begin
        m_good++;
        if (m_good == 3) begin m_good = 0; m_level--; end
      end
    end
    m_even = realign ? 1'b1 : !m_even;
  endtask

  function automatic int exp_state();
    if (m_sync) return 6 + m_level;
    if (m_acq == 0) return 0;
    return m_wantdata ? 2 * m_acq - 1 : 2 * m_acq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(bus.state), 32'(exp_state()));
    chk({tag, ".sync_ok"}, 32'(bus.sync_ok), 32'(m_sync));
    chk({tag, ".sync_lost"}, 32'(bus.sync_lost), 32'(m_lost));
    chk({tag, ".rx_even"}, 32'(bus.rx_even), 32'(m_even));
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
  endtask

  // One clock: drive at negedge, step model after posedge, compare 1 time unit later.
  task automatic drive(input string tag, input bit r, input bit e, input logic [1:0] cm,
                       input logic [1:0] k, input logic [1:0] de, input logic [1:0] ni,
                       input bit do_chk);
    @(negedge clk);
    rst = r; bus.en = e; bus.chariscomma = cm; bus.charisk = k;
    bus.disperr = de; bus.notintable = ni;
    @(posedge clk);
    if (r) model_reset();
    else begin
      m_lost = 0;
      if (e) for (int i = 0; i < 2; i++) model_char(cm[i], k[i], de[i], ni[i]);
    end
    #1;
    if (do_chk) chk_all(tag);
  endtask

  task automatic comma_data(input string tag);
    drive(tag, 0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 1);
  endtask

  task automatic rand_char(output bit cm, output bit k, output bit de, output bit ni);
    int r;
    r = $urandom_range(0, 99);
    cm = 0; k = 0; de = 0; ni = 0;
    if (r < 20) begin cm = 1; k = 1; end
    else if (r < 85) begin end
    else if (r < 90) k = 1;
    else if (r < 95) de = 1;
    else ni = 1;
  endtask

  initial begin
    logic [1:0] cm, k, de, ni;
    logic [3:0] st_hold;
    logic [15:0] err_hold;
    logic ev_hold;
    bit c0, k0, d0, n0;

    model_reset();
    bus.en = 0; bus.chariscomma = 0; bus.charisk = 0; bus.disperr = 0; bus.notintable = 0;
    drive("reset", 1, 0, 0, 0, 0, 0, 1);
    drive("reset", 1, 1, 2'b11, 2'b11, 0, 0, 1);
    chk("reset_state_const", 32'(bus.state), 0);
    chk("reset_err_const", 32'(bus.err_cnt), 0);

    // Acquire with {K28.5, D21.5} x3.
    comma_data("acq1");
    comma_data("acq2");
    comma_data("acq3");
    chk("acq_state_const", 32'(bus.state), 6);
    chk("acq_sync_ok_const", 32'(bus.sync_ok), 1);

    // One bad char in SA1 then four good chars.
    drive("sa_bad", 0, 1, 0, 0, 0, 2'b01, 1);
    chk("sa2_const", 32'(bus.state), 7);
    drive("sa_good1", 0, 1, 0, 0, 0, 0, 1);
    drive("sa_good2", 0, 1, 0, 0, 0, 0, 1);
    chk("back_sa1_const", 32'(bus.state), 6);

    // Four bad words, one good char between each: SA2, SA3, SA4, LOS.
    drive("lose1", 0, 1, 0, 0, 0, 2'b01, 1);
    drive("lose2", 0, 1, 0, 0, 0, 2'b01, 1);
    drive("lose3", 0, 1, 0, 0, 0, 2'b01, 1);
    chk("sa4_const", 32'(bus.state), 9);
    drive("lose4", 0, 1, 0, 0, 0, 2'b01, 1);
    chk("lost_pulse_const", 32'(bus.sync_lost), 1);
    chk("lost_sync_ok_const", 32'(bus.sync_ok), 0);
    drive("after_lost", 0, 1, 0, 0, 0, 0, 1);
    chk("lost_pulse_end_const", 32'(bus.sync_lost), 0);

    // AS1 then a comma arriving at odd position in lane 1.
    comma_data("as1");
    chk("as1_const", 32'(bus.state), 2);
    err_hold = bus.err_cnt;
    drive("odd_comma", 0, 1, 2'b10, 2'b10, 0, 0, 1);
    chk("odd_comma_los_const", 32'(bus.state), 0);
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
    chk("odd_comma_err_inc", 32'(bus.err_cnt), 32'(err_hold) + 1);
`else
    chk("odd_comma_err_zero", 32'(bus.err_cnt), 0);
`endif

    // Re-acquire, then hold with en=0 and garbage flags.
    comma_data("reacq1");
    comma_data("reacq2");
    comma_data("reacq3");
    st_hold = bus.state; ev_hold = bus.rx_even; err_hold = bus.err_cnt;
    for (int i = 0; i < 5; i++) begin
      drive("hold", 0, 0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1);
    end
    chk("hold_state", 32'(bus.state), 32'(st_hold));
    chk("hold_even", 32'(bus.rx_even), 32'(ev_hold));
    chk("hold_err", 32'(bus.err_cnt), 32'(err_hold));
    drive("rst_in_sa", 1, 1, 0, 0, 0, 0, 1);
    chk("rst_sa_state_const", 32'(bus.state), 0);
    chk("rst_sa_lost_const", 32'(bus.sync_lost), 0);

    // Random words, mostly well-formed comma/data pairs, with occasional en=0 and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        cm = 2'b01; k = 2'b01; de = 0; ni = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          rand_char(c0, k0, d0, n0);
          cm[i] = c0; k[i] = k0; de[i] = d0; ni[i] = n0;
        end
      end
      drive("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), cm, k, de, ni, 1);
    end

    // Saturation: every word is a comma then a disparity error, one counted bad char per word.
    drive("sat_rst", 1, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 70000; n++) begin
      drive("sat", 0, 1, 2'b01, 2'b01, 2'b11, 0, 0);
    end
    chk_all("sat_end");
`ifdef GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN
    chk("sat_err_const", 32'(bus.err_cnt), 32'hFFFF);
`else
    chk("noerr_const", 32'(bus.err_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gtxe2_chnl_rx_syncfsm.md
# gtxe2_chnl_rx_syncfsm

Character-synchronization state machine sitting directly downstream of the receiver's 8B/10B decoder, in the RXUSRCLK domain. It consumes the per-character decoder flags (comma, K, disparity error, not-in-table) and runs a comma-based acquire/lose-sync machine with even/odd code-group tracking, evaluating every character of a multi-character word in lane order. It reports link sync status, a loss-of-sync pulse for upper layers, and optionally a saturating code-group error count.

## Interface
- `lanes`, 2: characters per clock (legal: 1, 2, 4); lane 0 is the earliest character.
- `GOOD_CGS_MAX`, 3: consecutive good characters required to step back one SYNC_ACQ level.
- `clk` input 1: RXUSRCLK; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: 1 = evaluate this cycle's characters; 0 = hold all state and outputs.
- `chariscomma` input `lanes`: decoder comma flag per character.
- `charisk` input `lanes`: decoder K-character flag per character.
- `disperr` input `lanes`: running-disparity error per character.
- `notintable` input `lanes`: invalid code group per character.
- `sync_ok` output 1: 1 while in any SYNC_ACQ state.
- `sync_lost` output 1: one-cycle pulse on any transition from a SYNC_ACQ state to LOS.
- `rx_even` output 1: even/odd phase after the last evaluated character.
- `state` output 4: current state encoding (debug).
- `err_cnt` output 16: saturating count of bad characters (macro-gated, see Configuration).

## Operation
- Per character i: `cgbad = notintable[i] | disperr[i] | (chariscomma[i] & rx_even_before_i)` where comma at odd position is bad only in CD/AS/SA states, not LOS. `cgdata = ~charisk[i] & ~notintable[i] & ~disperr[i]`.
- rx_even toggles after every evaluated character; set to 1 (the comma is the even character, next is odd) whenever a comma moves LOS/ASn -> CDn.
- States (encoding): LOS=0, CD1=1, AS1=2, CD2=3, AS2=4, CD3=5, SA1=6, SA2=7, SA3=8, SA4=9.
- LOS: comma -> CD1; else stay.
- CDn: cgdata -> ASn (n=1,2) or SA1 (n=3); any other character -> LOS.
- ASn: comma at even phase -> CD(n+1); cgbad -> LOS; else stay.
- SA1: cgbad -> SA2, good_cgs=0; else stay.
- SAk (k=2..4): cgbad -> SA(k+1) (SA4 -> LOS), good_cgs=0; good char -> good_cgs+1; when good_cgs reaches GOOD_CGS_MAX with a good character -> SA(k-1), good_cgs=0.
- Characters of one word chain combinationally lane 0 -> lanes-1; only the final state/phase/counter is registered.
- good_cgs width: clog2(GOOD_CGS_MAX+1); never exceeds GOOD_CGS_MAX.

## Timing
- Latency: flags presented at edge N affect `state`, `sync_ok`, `rx_even` after edge N (visible cycle N+1).
- `sync_lost` asserted exactly one cycle, same cycle `sync_ok` first reads 0.
- Reset values: state=LOS (0), sync_ok=0, sync_lost=0, rx_even=0, good_cgs=0, err_cnt=0.
- rst wins over en; rst mid-sync forces LOS without a `sync_lost` pulse.
- en=0: no state, counter, or phase change; sync_lost=0.
- Multiple transitions within one word are legal (e.g. SA4 -> LOS -> CD1 in one cycle); sync_lost pulses if the word started in SA and ended outside SA, or passed through LOS from SA.

## Configuration
- `GTXE2_CHNL_RX_SYNCFSM_ERRCNT_EN` defined: `err_cnt` increments by the number of cgbad characters per evaluated word (all states except LOS), saturates at 16'hFFFF, cleared only by rst.
- Not defined: `err_cnt` port exists, tied to 0; no counter logic.

## Test plan
- Reset then lanes=2, words {K28.5 comma, D21.5} x3 with correct phase -> sync_ok=1 on cycle after third word; state=6.
- In SA1, one word with notintable=2'b01 -> state=7; then 4 good characters (2 words) -> state=6.
- In SA1, four bad words spaced by <3 good chars -> SA4 then LOS; sync_lost=1 for one cycle, sync_ok=0.
- Comma in lane 1 while rx_even=1 during AS1 -> state=LOS; err_cnt +1 (macro defined).
- en=0 for 5 cycles with garbage flags -> state, rx_even, err_cnt unchanged; rst asserted in SA1 -> state=0, sync_lost stays 0.
- Macro defined, 70000 cycles of disperr=2'b11 -> err_cnt holds 16'hFFFF; macro undefined -> err_cnt=0.
